icache_responder: RTL and testbench
===================================

// Module: icache_responder
// PURPOSE
//   Direct-mapped, one-word-per-frame instruction cache. It is the responder on
//   the instruction side of datapath_cache_if: serves imemREN/imemaddr from the
//   datapath with ihit/imemload.
//   On a miss it issues a single-word fill on the memory-side port (iREN/iaddr,
//   iwait/iload) toward the memory controller.
//   Carries hit/miss performance counters for the testbench and for sim dumps.
// PARAMETERS
//   IDX_W    4    index bits; SETS = 2**IDX_W frames (default 16)
//   CNT_W    32   width of hit_count / miss_count
// PORTS
//   CLK         in   1      clock, all state updates on posedge
//   RST         in   1      asynchronous, active-high reset
//   imemREN     in   1      datapath instruction read request (held high while waiting)
//   imemaddr    in   32     datapath byte address (PC); bits [1:0] ignored
//   halt        in   1      datapath halt latch; once high stays high until RST
//   ihit        out  1      requested word valid on imemload this cycle
//   imemload    out  32     instruction word to the datapath
//   iREN        out  1      memory-side fill request
//   iaddr       out  32     memory-side word address, always {addr[31:2],2'b00}
//   iwait       in   1      memory busy; fill data valid in the cycle iwait==0
//   iload       in   32     fill data from memory
//   hit_count   out  CNT_W  cycles with ihit==1 (saturating)
//   miss_count  out  CNT_W  fills started (saturating)
// BEHAVIOUR
//   Reset: one clock, asynchronous and active-high (RST).
//   While RST=1: all valid bits 0, state=COMPARE, req_addr=0, both counters 0.
//   While RST=1: ihit=0, iREN=0, iaddr=0, imemload=0.
//   Address split: tag=[31:IDX_W+2], index=[IDX_W+1:2], offset=[1:0] ignored.
//   Frame storage: valid, tag and 32-bit data per set. Data/tag need no reset.
//   FSM has two states, COMPARE and FILL.
//   COMPARE:
//     hit = imemREN & ~halt & valid[idx] & (tag[idx]==addr tag).
//     ihit=hit and imemload=data[idx] are combinational (zero-latency hit).
//     When ihit=0, imemload=0.
//     On imemREN & ~halt & ~hit: latch req_addr={imemaddr[31:2],2'b00}.
//     On the same miss: increment miss_count and go to FILL next cycle.
//   FILL:
//     ihit=0, iREN=1, iaddr=req_addr (registered, stable for the whole fill).
//     iwait=1: stay in FILL.
//     iwait=0: write data[idx]=iload, write tag[idx]=req_addr tag,
//     set valid[idx]=1, return to COMPARE.
//     The re-presented request then hits; miss latency = fill wait + 2 cycles.
//   The fill always completes, even if imemaddr changes mid-fill (pipeline
//   flush/branch). The filled frame is kept, and COMPARE re-evaluates the
//   new address.
//   halt=1 in COMPARE: ihit=0, no new fill, counters frozen.
//   halt=1 in FILL: the current fill finishes, then the FSM idles in COMPARE.
//   imemREN=0: no hit, no miss, no counter activity.
//   Replacement: a fill to an occupied index overwrites it. No write path and
//   no invalidation other than RST.
//   Counters: hit_count += 1 on every cycle with ihit=1; miss_count += 1 on
//   each COMPARE->FILL. Both stick at all-ones and never wrap.
//   RST during FILL: aborts immediately. iREN drops asynchronously, no frame
//   is written, and the FSM restarts in COMPARE with all frames invalid.
//   iaddr is a registered output; ihit and imemload are combinational.
// TESTING
//   1. Cold miss: RST, imemaddr=0x0000_0040, iwait=1 for 3 cycles then 0 with
//      iload=0x2001_0005.
//      -> iREN high 4 cycles with iaddr=0x40; ihit=1 next cycle with
//      imemload=0x2001_0005; miss_count=1.
//   2. Warm hit: after (1), present 0x40 for 5 cycles
//      -> ihit=1 every cycle, iREN=0, hit_count=6.
//   3. Conflict: fill 0x40 then 0x80 (both index 0), then re-request 0x40
//      -> re-request misses again; miss_count=3; iaddr=0x40 on the third fill.
//   4. Address change mid-fill: miss on 0x100, switch imemaddr to 0x104 while
//      iwait=1.
//      -> fill completes to 0x100; next cycle misses on 0x104; both frames
//      then valid.
//   5. Halt: set halt=1 during a fill of 0x200
//      -> fill completes; afterwards ihit=0 and iREN=0 for 10 cycles, and the
//      counters are unchanged.
//   6. Reset mid-fill: assert RST while iREN=1
//      -> iREN=0 the same cycle; after release, 0x40 misses (frames cleared)
//      and counters are 0.

Source files
------------

// File: rtl/icache_responder_if.sv
// Datapath-side and memory-side instruction fetch signals
// for the direct-mapped instruction cache.
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, halt,
    input  iwait, iload,
    output ihit, imemload,
    output iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, halt,
    output iwait, iload,
    input  ihit, imemload,
    input  iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped one-word-per-frame instruction cache with
// single-word miss fills and saturating hit/miss counters.
module icache_responder #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  icache_responder_if.slave cif,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {COMPARE, FILL} state_t;

  state_t            state;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [31:0]       data [SETS];
  logic [31:0]       req_addr;

  logic [IDX_W-1:0]  cidx, fidx;
  logic [TAG_W-1:0]  ctag, ftag;
  logic              req, hit, done;

  assign cidx = cif.imemaddr[IDX_W+1:2];
  assign ctag = cif.imemaddr[31:IDX_W+2];
  assign fidx = req_addr[IDX_W+1:2];
  assign ftag = req_addr[31:IDX_W+2];

  assign req  = cif.imemREN & ~cif.halt;
  assign hit  = (state == COMPARE) & req & valid[cidx] &
                (tags[cidx] == ctag);
  assign done = (state == FILL) & ~cif.iwait;

  assign cif.ihit     = hit;
  assign cif.imemload = hit ? data[cidx] : 32'h0;
  assign cif.iREN     = (state == FILL);
  assign cif.iaddr    = req_addr;

  // Data and tag need no reset; valid gates their use.
  always_ff @(posedge CLK) begin
    if (done) begin
      data[fidx] <= cif.iload;
      tags[fidx] <= ftag;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= COMPARE;
      valid      <= '0;
      req_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1)
        hit_count <= hit_count + CNT_W'(1);
      unique case (state)
        COMPARE: begin
          if (req && !hit) begin
            req_addr <= {cif.imemaddr[31:2], 2'b00};
            state    <= FILL;
            if (miss_count != '1)
              miss_count <= miss_count + CNT_W'(1);
          end
        end
        FILL: begin
          if (!cif.iwait) begin
            valid[fidx] <= 1'b1;
            state       <= COMPARE;
          end
        end
        default: state <= COMPARE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: fetches push expected
// words, hits pop and compare; counters tracked by the bench.
module tb_icache_responder;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] hit_count, miss_count;
  icache_responder_if cif ();

  icache_responder #(.IDX_W(4), .CNT_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cif        (cif),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          e_hit = 0;
  int          e_miss = 0;
  int          f;
  logic [31:0] sb [$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h40) return 32'h2001_0005;
    return a ^ 32'hC0DE_0001;
  endfunction

  // Called at a negedge; returns at the negedge after the hit.
  task automatic fetch(input logic [31:0] a, input int waits,
                       output int fc);
    bit done = 0;
    fc = 0;
    cif.imemaddr = a;
    cif.imemREN  = 1'b1;
    sb.push_back(memword(a));
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (cif.ihit) begin
        check("word", cif.imemload, sb.pop_front());
        done = 1;
      end else if (cif.iREN) begin
        check("iaddr", cif.iaddr, a);
        cif.iwait = (fc < waits);
        cif.iload = memword(a);
        fc++;
      end
      @(negedge CLK);
    end
    if (!done) begin
      check("timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    if (fc > 0) e_miss++;
    if (done) e_hit++;
    cif.imemREN = 1'b0;
    cif.iwait   = 1'b1;
  endtask

  task automatic cnts(input string tag);
    check({tag, "_hits"}, hit_count, e_hit);
    check({tag, "_miss"}, miss_count, e_miss);
  endtask

  initial begin
    RST          = 1'b1;
    cif.imemREN  = 1'b0;
    cif.imemaddr = '0;
    cif.halt     = 1'b0;
    cif.iwait    = 1'b1;
    cif.iload    = '0;
    repeat (2) @(negedge CLK);
    check("rst_ihit", {31'd0, cif.ihit}, 32'd0);
    check("rst_iren", {31'd0, cif.iREN}, 32'd0);
    check("rst_iaddr", cif.iaddr, 32'd0);
    check("rst_load", cif.imemload, 32'd0);
    cnts("rst");
    RST = 1'b0;
    @(negedge CLK);

    // cold miss
    fetch(32'h40, 3, f);
    check("cold_fill", f, 32'd4);
    cnts("cold");

    // warm hits
    cif.imemaddr = 32'h40;
    cif.imemREN  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(memword(32'h40));
      #1;
      check("warm_ihit", {31'd0, cif.ihit}, 32'd1);
      check("warm_iren", {31'd0, cif.iREN}, 32'd0);
      check("warm_word", cif.imemload, sb.pop_front());
      @(negedge CLK);
    end
    e_hit += 5;
    cif.imemREN = 1'b0;
    #1;
    check("noren_ihit", {31'd0, cif.ihit}, 32'd0);
    check("noren_load", cif.imemload, 32'd0);
    repeat (3) @(negedge CLK);
    check("warm_hits6", hit_count, 32'd6);
    cnts("warm");

    // conflict on index 0
    fetch(32'h80, 2, f);
    check("conf_fill", f, 32'd3);
    fetch(32'h40, 1, f);
    check("conf_refill", f, 32'd2);
    check("conf_miss3", miss_count, 32'd3);

    // address change mid-fill
    cif.imemaddr = 32'h100;
    cif.imemREN  = 1'b1;
    @(negedge CLK);
    #1;
    check("mid_iren", {31'd0, cif.iREN}, 32'd1);
    cif.iwait    = 1'b1;
    cif.imemaddr = 32'h104;
    @(negedge CLK);
    #1;
    check("mid_iaddr", cif.iaddr, 32'h100);
    cif.iwait = 1'b0;
    cif.iload = memword(32'h100);
    @(negedge CLK);
    e_miss++;
    fetch(32'h104, 1, f);
    check("mid_newmiss", {31'd0, f > 0}, 32'd1);
    fetch(32'h100, 0, f);
    check("mid_v100", f, 32'd0);
    fetch(32'h104, 0, f);
    check("mid_v104", f, 32'd0);
    cnts("mid");

    // halt during fill
    cif.imemaddr = 32'h200;
    cif.imemREN  = 1'b1;
    @(negedge CLK);
    cif.iwait = 1'b1;
    cif.halt  = 1'b1;
    @(negedge CLK);
    cif.iwait = 1'b0;
    cif.iload = memword(32'h200);
    @(negedge CLK);
    e_miss++;
    cif.iwait = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("halt_ihit", {31'd0, cif.ihit}, 32'd0);
      check("halt_iren", {31'd0, cif.iREN}, 32'd0);
      @(negedge CLK);
    end
    cnts("halt");

    // reset mid-fill
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    cif.halt = 1'b0;
    e_hit = 0;
    e_miss = 0;
    cif.imemaddr = 32'h300;
    cif.imemREN  = 1'b1;
    @(negedge CLK);
    cif.iwait = 1'b1;
    #1;
    check("rf_iren1", {31'd0, cif.iREN}, 32'd1);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("rf_iren0", {31'd0, cif.iREN}, 32'd0);
    check("rf_iaddr", cif.iaddr, 32'd0);
    cnts("rf");
    @(negedge CLK);
    RST = 1'b0;
    cif.imemREN = 1'b0;
    @(negedge CLK);
    fetch(32'h40, 0, f);
    check("rf_cleared", {31'd0, f > 0}, 32'd1);
    cnts("rf_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
